horner_seq_ctrl: RTL and testbench
==================================

HORNER_SEQ_CTRL -- requirements
Module: horner_seq_ctrl

Interface
REQ-001 The parameter DEGREE SHALL default to 10 and set the polynomial degree (coefficients a0..aDEGREE); legal range is 1..15.
REQ-002 The parameter CS_DELAY SHALL default to 18 and set the center/scale pipeline latency in cycles; legal minimum is 2.
REQ-003 The parameter ITER_DELAY SHALL default to 16 and set the latency of one Horner iteration in cycles; legal minimum is 1.
REQ-004 The parameter TAIL_DELAY SHALL default to 19 and set the latency from the last coefficient select to valid output; legal minimum is 1.
REQ-005 The parameter RETRIGGER SHALL default to 0: 0 ignores srdyi while busy, and 1 restarts the sequence.
REQ-006 The port clk SHALL be an input, 1 bit wide, and be the single clock; all state changes on its rising edge.
REQ-007 The port GlobalReset SHALL be an input, 1 bit wide, with synchronous active-low reset.
REQ-008 The port srdyi SHALL be an input, 1 bit wide, and be a single-cycle start pulse from upstream.
REQ-009 The port drdyi SHALL be an input, 1 bit wide, and signal that downstream accepts the result.
REQ-010 The port coeff_sel SHALL be an output, SEL_W bits wide, and be the coefficient mux select.
REQ-011 The port sum_rst SHALL be an output, 1 bit wide, and clear the accumulator.
REQ-012 The port sum_en SHALL be an output, 1 bit wide, and enable the accumulator.
REQ-013 The port srdyo SHALL be an output, 1 bit wide, and signal that the result is valid.
REQ-014 The port busy SHALL be an output, 1 bit wide, and be high in any state other than IDLE.
REQ-015 The port overrun SHALL be an output, 1 bit wide, and be a one-cycle pulse when srdyi is dropped.

Function
REQ-016 The block SHALL define T_LOOP = CS_DELAY + DEGREE*ITER_DELAY and T_DONE = T_LOOP + TAIL_DELAY; a cycle counter cnt SHALL be CNT_W = clog2(T_DONE+1) bits wide.
REQ-017 The FSM SHALL have the states IDLE, CENTER, LOOP, TAIL and DONE, all registered.
REQ-018 A start SHALL be accepted when srdyi is high in IDLE: the next state is CENTER with cnt=1.
REQ-019 sum_rst SHALL be high exactly when cnt==1, i.e. one cycle after start acceptance.
REQ-020 The FSM SHALL go CENTER->LOOP when cnt reaches CS_DELAY, LOOP->TAIL when cnt reaches T_LOOP+1, and TAIL->DONE when cnt reaches T_DONE; cnt SHALL increment by 1 each cycle outside IDLE and DONE.
REQ-021 coeff_sel SHALL be loaded with DEGREE-k when cnt==CS_DELAY+k*ITER_DELAY for k=0..DEGREE, and SHALL hold its value otherwise.
REQ-022 sum_en SHALL be high when cnt>=CS_DELAY, and SHALL stay high through DONE.
REQ-023 srdyo SHALL be high throughout DONE and SHALL stay high until drdyi is sampled high; DONE then goes to IDLE, with srdyo low on the following cycle.
REQ-024 If srdyo and drdyi are high together with srdyi high in DONE, the block SHALL accept the new start back-to-back (next state CENTER, cnt=1) with no IDLE cycle.
REQ-025 With RETRIGGER=0, srdyi while busy (including DONE without drdyi) SHALL be ignored and SHALL pulse overrun for one cycle.
REQ-026 With RETRIGGER=1, srdyi in CENTER/LOOP/TAIL SHALL restart at cnt=1 with no overrun pulse; srdyi in DONE without drdyi SHALL still be dropped with an overrun pulse.
REQ-027 cnt SHALL never wrap; exceeding T_DONE is unreachable by design and SHALL be covered by an assertion.

Reset
REQ-028 While GlobalReset is low at a clock edge, the block SHALL set state=IDLE and cnt=0.
REQ-029 Under reset, the block SHALL set coeff_sel=DEGREE, sum_rst=0, sum_en=0, srdyo=0, busy=0 and overrun=0.
REQ-030 Reset mid-sequence SHALL abort the sequence with no srdyo, and SHALL ignore srdyi in the same cycle.

Configuration
REQ-031 With HORNER_SEQ_DBG_CNT_EN defined, the block SHALL add the output port dbg_cnt[CNT_W-1:0] mirroring cnt.
REQ-032 With HORNER_SEQ_DBG_CNT_EN defined, the block SHALL add a saturating 8-bit output port dbg_ovr_cnt counting overrun pulses, cleared by reset.
REQ-033 Without HORNER_SEQ_DBG_CNT_EN defined, the block SHALL have neither dbg_cnt nor dbg_ovr_cnt ports, and behaviour SHALL otherwise be identical.

Structure
REQ-034 The package horner_seq_pkg SHALL hold the state enum and the default delay constants.
REQ-035 The package horner_seq_pkg SHALL hold the functions that compute SEL_W, CNT_W, T_LOOP and T_DONE from the parameters.
REQ-036 The sub-module horner_seq_lut SHALL map cnt to a coefficient-load strobe and index; the FSM, counter and handshake logic SHALL live in the top module.

Verification
REQ-037 With defaults, a srdyi pulse at cycle 0 and drdyi held high SHALL give sum_rst at cycle 1 and coeff_sel=10 at cnt 18, 9 at 34 and 0 at 178.
REQ-038 With defaults and drdyi held high, srdyo SHALL be high for exactly one cycle at cnt 197, and busy SHALL fall the cycle after.
REQ-039 With drdyi low until 5 cycles after DONE entry, srdyo SHALL be held high for those 6 cycles and SHALL fall 1 cycle after drdyi rises.
REQ-040 With RETRIGGER=0, a srdyi at cnt 50 SHALL pulse overrun with no change to the sequence.
REQ-041 With RETRIGGER=1, a srdyi at cnt 50 SHALL restart the sequence and give srdyo 197 cycles after the restart pulse.
REQ-042 GlobalReset held low for one cycle at cnt 100 SHALL put all outputs at reset values, and no srdyo SHALL occur.
REQ-043 With DEGREE=3, CS_DELAY=2, ITER_DELAY=1 and TAIL_DELAY=1, coeff_sel SHALL step 3,2,1,0 at cnt 2..5, and srdyo SHALL assert at cnt 6.
REQ-044 In DONE, srdyi and drdyi high in the same cycle SHALL give a back-to-back restart with cnt=1 and sum_rst on the next cycle.

Source files
------------

// File: rtl/horner_seq_pkg.sv
// horner_seq_pkg: state encoding, default delays and derived-width helpers for the Horner sequencer.
package horner_seq_pkg;

    typedef enum logic [2:0] {IDLE, CENTER, LOOP, TAIL, DONE} state_e;

    localparam int DEF_DEGREE     = 10;
    localparam int DEF_CS_DELAY   = 18;
    localparam int DEF_ITER_DELAY = 16;
    localparam int DEF_TAIL_DELAY = 19;

    function automatic int sel_w(input int degree);
        return $clog2(degree + 1);
    endfunction

    function automatic int t_loop(input int cs, input int degree, input int iter);
        return cs + degree * iter;
    endfunction

    function automatic int t_done(input int cs, input int degree, input int iter, input int tail);
        return t_loop(cs, degree, iter) + tail;
    endfunction

    function automatic int cnt_w(input int cs, input int degree, input int iter, input int tail);
        return $clog2(t_done(cs, degree, iter, tail) + 1);
    endfunction

endpackage

// File: rtl/horner_seq_ctrl_if.sv
// horner_seq_ctrl_if: start/result handshake and datapath controls of the Horner sequencer.
interface horner_seq_ctrl_if
    import horner_seq_pkg::*;
#(
    parameter int SEL_W = sel_w(DEF_DEGREE)
);
    logic             srdyi;
    logic             drdyi;
    logic [SEL_W-1:0] coeff_sel;
    logic             sum_rst;
    logic             sum_en;
    logic             srdyo;
    logic             busy;
    logic             overrun;

    modport master (
        output srdyi, drdyi,
        input  coeff_sel, sum_rst, sum_en, srdyo, busy, overrun
    );

    modport slave (
        input  srdyi, drdyi,
        output coeff_sel, sum_rst, sum_en, srdyo, busy, overrun
    );
endinterface

// File: rtl/horner_seq_lut.sv
// horner_seq_lut: decodes the cycle count into a coefficient-load strobe and the coefficient index.
module horner_seq_lut #(
    parameter int DEGREE     = 10,
    parameter int CS_DELAY   = 18,
    parameter int ITER_DELAY = 16,
    parameter int CNT_W      = 8,
    parameter int SEL_W      = 4
) (
    input  logic [CNT_W-1:0] cnt_i,
    output logic             load_o,
    output logic [SEL_W-1:0] idx_o
);
    always_comb begin
        load_o = 1'b0;
        idx_o  = '0;
        for (int k = 0; k <= DEGREE; k++) begin
            if (cnt_i == CNT_W'(CS_DELAY + k * ITER_DELAY)) begin
                load_o = 1'b1;
                idx_o  = SEL_W'(DEGREE - k);
            end
        end
    end
endmodule

// File: rtl/horner_seq_ctrl.sv
// horner_seq_ctrl: cycle-counted FSM sequencing center/scale, Horner iterations and result handshake.
// Defining HORNER_SEQ_DBG_CNT_EN adds the dbg_cnt and dbg_ovr_cnt observation ports.
module horner_seq_ctrl
    import horner_seq_pkg::*;
#(
    parameter int DEGREE     = DEF_DEGREE,
    parameter int CS_DELAY   = DEF_CS_DELAY,
    parameter int ITER_DELAY = DEF_ITER_DELAY,
    parameter int TAIL_DELAY = DEF_TAIL_DELAY,
    parameter int RETRIGGER  = 0,
    localparam int SEL_W     = sel_w(DEGREE),
    localparam int CNT_W     = cnt_w(CS_DELAY, DEGREE, ITER_DELAY, TAIL_DELAY)
) (
    input  logic             clk,
    input  logic             GlobalReset,
    horner_seq_ctrl_if.slave bus
`ifdef HORNER_SEQ_DBG_CNT_EN
    ,
    output logic [CNT_W-1:0] dbg_cnt,
    output logic [7:0]       dbg_ovr_cnt
`endif
);
    localparam logic [CNT_W-1:0] C_CS   = CNT_W'(CS_DELAY);
    localparam logic [CNT_W-1:0] C_TAIL = CNT_W'(t_loop(CS_DELAY, DEGREE, ITER_DELAY) + 1);
    localparam logic [CNT_W-1:0] C_DONE = CNT_W'(t_done(CS_DELAY, DEGREE, ITER_DELAY, TAIL_DELAY));
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] coeff_q, coeff_d, lut_idx;
    logic             overrun_q, drop, lut_load, active;

    horner_seq_lut #(
        .DEGREE    (DEGREE),
        .CS_DELAY  (CS_DELAY),
        .ITER_DELAY(ITER_DELAY),
        .CNT_W     (CNT_W),
        .SEL_W     (SEL_W)
    ) u_lut (
        .cnt_i (cnt_d),
        .load_o(lut_load),
        .idx_o (lut_idx)
    );

    // DONE takes priority so a one-cycle TAIL still lands on T_DONE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drop    = 1'b0;
        active  = state_q inside {CENTER, LOOP, TAIL};
        if (active) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = cnt_d == C_DONE ? DONE :
                      cnt_d == C_TAIL ? TAIL :
                      cnt_d == C_CS   ? LOOP : state_q;
            if (bus.srdyi) begin
                if (RETRIGGER != 0) begin
                    state_d = CENTER;
                    cnt_d   = C_ONE;
                end else begin
                    drop = 1'b1;
                end
            end
        end else if (state_q == DONE) begin
            if (bus.drdyi) begin
                state_d = bus.srdyi ? CENTER : IDLE;
                cnt_d   = bus.srdyi ? C_ONE : '0;
            end else begin
                drop = bus.srdyi;
            end
        end else if (bus.srdyi) begin
            state_d = CENTER;
            cnt_d   = C_ONE;
        end
        coeff_d = lut_load ? lut_idx : coeff_q;
    end

    always_ff @(posedge clk) begin
        if (!GlobalReset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            coeff_q   <= SEL_W'(DEGREE);
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            coeff_q   <= coeff_d;
            overrun_q <= drop;
        end
    end

    assign bus.coeff_sel = coeff_q;
    assign bus.sum_rst   = cnt_q == C_ONE;
    assign bus.sum_en    = cnt_q >= C_CS;
    assign bus.srdyo     = state_q == DONE;
    assign bus.busy      = state_q != IDLE;
    assign bus.overrun   = overrun_q;

`ifdef HORNER_SEQ_DBG_CNT_EN
    logic [7:0] dbg_ovr_q;

    always_ff @(posedge clk) begin
        if (!GlobalReset) dbg_ovr_q <= '0;
        else if (drop && dbg_ovr_q != 8'hFF) dbg_ovr_q <= dbg_ovr_q + 8'd1;
    end

    assign dbg_cnt     = cnt_q;
    assign dbg_ovr_cnt = dbg_ovr_q;
`endif

    cnt_bound: assert property (@(posedge clk) disable iff (!GlobalReset) cnt_q <= C_DONE);

endmodule

// File: tb/tb_horner_seq_ctrl.sv
// tb_horner_seq_ctrl: directed checks of default, retrigger and minimal-delay sequencer builds.
module tb_horner_seq_ctrl;
    import horner_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cur = 0;
    int   seen = 0;

    horner_seq_ctrl_if #(.SEL_W(sel_w(10))) ia ();
    horner_seq_ctrl_if #(.SEL_W(sel_w(10))) ib ();
    horner_seq_ctrl_if #(.SEL_W(sel_w(3)))  ic ();

    horner_seq_ctrl u_a (.clk(clk), .GlobalReset(rst_n), .bus(ia.slave));
    horner_seq_ctrl #(.RETRIGGER(1)) u_b (.clk(clk), .GlobalReset(rst_n), .bus(ib.slave));
    horner_seq_ctrl #(.DEGREE(3), .CS_DELAY(2), .ITER_DELAY(1), .TAIL_DELAY(1))
        u_c (.clk(clk), .GlobalReset(rst_n), .bus(ic.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cnt %0d)", tag, act, exp, cur);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cur++;
    endtask

    task automatic go(input int n);
        while (cur < n) tick();
    endtask

    task automatic start(input int which);
        ia.srdyi = (which == 0);
        ib.srdyi = (which == 1);
        ic.srdyi = (which == 2);
        cur = 0;
        tick();
        ia.srdyi = 1'b0;
        ib.srdyi = 1'b0;
        ic.srdyi = 1'b0;
    endtask

    initial begin
        ia.srdyi = 1'b0; ia.drdyi = 1'b1;
        ib.srdyi = 1'b0; ib.drdyi = 1'b0;
        ic.srdyi = 1'b0; ic.drdyi = 1'b1;
        tick();
        tick();
        check("rst_coeff", ia.coeff_sel, 10);
        check("rst_sum_rst", ia.sum_rst, 0);
        check("rst_sum_en", ia.sum_en, 0);
        check("rst_srdyo", ia.srdyo, 0);
        check("rst_busy", ia.busy, 0);
        check("rst_overrun", ia.overrun, 0);
        rst_n = 1'b1;
        tick();

        start(0);
        check("seq_sum_rst1", ia.sum_rst, 1);
        check("seq_busy1", ia.busy, 1);
        check("seq_sum_en1", ia.sum_en, 0);
        tick();
        check("seq_sum_rst2", ia.sum_rst, 0);
        go(17);  check("seq_sum_en17", ia.sum_en, 0);
        go(18);  check("seq_sum_en18", ia.sum_en, 1);
        check("seq_coeff18", ia.coeff_sel, 10);
        go(33);  check("seq_coeff33", ia.coeff_sel, 10);
        go(34);  check("seq_coeff34", ia.coeff_sel, 9);
        go(177); check("seq_coeff177", ia.coeff_sel, 1);
        go(178); check("seq_coeff178", ia.coeff_sel, 0);
        go(196); check("seq_srdyo196", ia.srdyo, 0);
        go(197); check("seq_srdyo197", ia.srdyo, 1);
        check("seq_busy197", ia.busy, 1);
        check("seq_sum_en197", ia.sum_en, 1);
        tick();
        check("seq_srdyo_end", ia.srdyo, 0);
        check("seq_busy_end", ia.busy, 0);
        check("seq_sum_en_end", ia.sum_en, 0);

        start(0);
        go(50);
        ia.srdyi = 1'b1;
        tick();
        ia.srdyi = 1'b0;
        check("ovr_pulse", ia.overrun, 1);
        check("ovr_no_restart", ia.sum_rst, 0);
        tick();
        check("ovr_one_cycle", ia.overrun, 0);
        go(196); check("ovr_srdyo196", ia.srdyo, 0);
        go(197); check("ovr_srdyo197", ia.srdyo, 1);
        tick();

        ia.drdyi = 1'b0;
        start(0);
        go(197);
        check("hold_e0", ia.srdyo, 1);
        ia.srdyi = 1'b1;
        tick();
        ia.srdyi = 1'b0;
        check("hold_e1", ia.srdyo, 1);
        check("hold_done_ovr", ia.overrun, 1);
        tick();
        check("hold_e2", ia.srdyo, 1);
        check("hold_done_ovr_end", ia.overrun, 0);
        tick(); check("hold_e3", ia.srdyo, 1);
        tick(); check("hold_e4", ia.srdyo, 1);
        tick(); check("hold_e5", ia.srdyo, 1);
        ia.drdyi = 1'b1;
        tick();
        check("hold_e6", ia.srdyo, 0);
        check("hold_busy_e6", ia.busy, 0);

        start(0);
        go(197);
        ia.srdyi = 1'b1;
        cur = 0;
        tick();
        ia.srdyi = 1'b0;
        check("b2b_sum_rst", ia.sum_rst, 1);
        check("b2b_srdyo", ia.srdyo, 0);
        check("b2b_busy", ia.busy, 1);
        check("b2b_overrun", ia.overrun, 0);
        go(197); check("b2b_srdyo197", ia.srdyo, 1);
        tick();

        start(0);
        go(100);
        check("rst_mid_coeff", ia.coeff_sel, 5);
        rst_n = 1'b0;
        ia.srdyi = 1'b1;
        tick();
        ia.srdyi = 1'b0;
        check("rstm_coeff", ia.coeff_sel, 10);
        check("rstm_sum_en", ia.sum_en, 0);
        check("rstm_sum_rst", ia.sum_rst, 0);
        check("rstm_busy", ia.busy, 0);
        check("rstm_srdyo", ia.srdyo, 0);
        check("rstm_overrun", ia.overrun, 0);
        rst_n = 1'b1;
        repeat (220) begin
            tick();
            seen += int'(ia.srdyo | ia.busy);
        end
        check("rstm_quiet", seen, 0);

        start(1);
        go(50);
        ib.srdyi = 1'b1;
        cur = 0;
        tick();
        ib.srdyi = 1'b0;
        check("rt_no_overrun", ib.overrun, 0);
        check("rt_sum_rst", ib.sum_rst, 1);
        go(196); check("rt_srdyo196", ib.srdyo, 0);
        go(197); check("rt_srdyo197", ib.srdyo, 1);
        ib.srdyi = 1'b1;
        tick();
        ib.srdyi = 1'b0;
        check("rt_done_ovr", ib.overrun, 1);
        check("rt_done_hold", ib.srdyo, 1);
        check("rt_done_no_restart", ib.sum_rst, 0);
        ib.drdyi = 1'b1;
        tick();
        check("rt_srdyo_end", ib.srdyo, 0);

        start(2);
        check("min_sum_rst", ic.sum_rst, 1);
        check("min_sum_en1", ic.sum_en, 0);
        tick(); check("min_coeff2", ic.coeff_sel, 3);
        check("min_sum_en2", ic.sum_en, 1);
        tick(); check("min_coeff3", ic.coeff_sel, 2);
        tick(); check("min_coeff4", ic.coeff_sel, 1);
        tick(); check("min_coeff5", ic.coeff_sel, 0);
        check("min_srdyo5", ic.srdyo, 0);
        tick(); check("min_srdyo6", ic.srdyo, 1);
        tick(); check("min_srdyo_end", ic.srdyo, 0);
        check("min_busy_end", ic.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
